// File: rtl/exec_ctrl_pkg.sv
// ============================================================================
//  exec_ctrl_pkg : opcodes, EX-stage state encoding and capture decode helper
//  Revision      : 1.0
// ============================================================================
`default_nettype none

package exec_ctrl_pkg;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_MEM  = 2'd2
   } state_t;

   // State entered when a decode-stage instruction is captured into EX.
   function automatic state_t capture_state(input logic valid, input logic [6:0] opcode);
      if (!valid)
         return ST_IDLE;
      else if (opcode == OP_LOAD || opcode == OP_STORE)
         return ST_MEM;
      else
         return ST_EXEC;
   endfunction

endpackage

`default_nettype wire

// File: rtl/exec_ctrl_load_use_detect.sv
// ============================================================================
//  load_use_detect : flags a decode-stage source that reads the register a
//                    load is writing back in its acknowledge cycle
//  Revision        : 1.0
// ============================================================================
`default_nettype none

module load_use_detect (
   input  logic       load_ack,
   input  logic       id_valid,
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   input  logic [4:0] ex_rd,
   output logic       hazard
);

   always_comb begin
      hazard = load_ack && id_valid && (ex_rd != 5'd0) &&
               ((id_rs1 == ex_rd) || (id_rs2 == ex_rd));
   end

endmodule

`default_nettype wire

// File: rtl/exec_ctrl.sv
// ============================================================================
//  exec_ctrl : execute-stage controller -- EX register, memory wait FSM with
//              timeout, load-use bubble, mispredict flush, write-back enable
//  Revision  : 1.0
// ============================================================================
`default_nettype none

module exec_ctrl
   import exec_ctrl_pkg::*;
#(
   parameter int unsigned MAX_WAIT = 15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       id_valid,
   input  logic [6:0] id_opcode,
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   input  logic [4:0] id_rd,
   output logic       id_ready,
   input  logic       branch_mispredicted_in,
   input  logic       mem_ack_in,
   output logic       ex_valid_out,
   output logic       ex_stall_out,
   output logic       flush_out,
   output logic       mem_req_out,
   output logic       mem_we_out,
   output logic       rd_write_out,
   output logic [4:0] rd_out,
   output logic       mem_error_out
);

   localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

   state_t     state, state_nxt;
   logic [6:0] ex_opcode;
   logic [4:0] ex_rd;
   logic [7:0] wait_cnt, wait_cnt_nxt;
   logic       mem_error;
   logic       in_mem, load_ack, hazard, timeout, capture;

   load_use_detect u_load_use (
      .load_ack (load_ack),
      .id_valid (id_valid),
      .id_rs1   (id_rs1),
      .id_rs2   (id_rs2),
      .ex_rd    (ex_rd),
      .hazard   (hazard)
   );

   always_comb begin
      in_mem        = (state == ST_MEM);
      load_ack      = in_mem && mem_ack_in && (ex_opcode == OP_LOAD);
      // Ack has priority: the timeout only fires on a non-acknowledged cycle.
      timeout       = in_mem && !mem_ack_in && (wait_cnt == WAIT_LAST);
      ex_valid_out  = (state != ST_IDLE);
      ex_stall_out  = in_mem && !mem_ack_in;
      flush_out     = (state == ST_EXEC) && branch_mispredicted_in;
      id_ready      = !ex_stall_out && !hazard;
      mem_req_out   = in_mem;
      mem_we_out    = in_mem && (ex_opcode == OP_STORE);
      rd_out        = ex_rd;
      mem_error_out = mem_error;
      rd_write_out  = (ex_rd != 5'd0) &&
                      (((state == ST_EXEC) && (ex_opcode != OP_STORE) &&
                        (ex_opcode != OP_BRANCH)) || load_ack);
      capture       = id_ready && !flush_out;
   end

   always_comb begin
      state_nxt    = ST_IDLE;
      wait_cnt_nxt = 8'd0;
      if (capture) begin
         state_nxt = capture_state(id_valid, id_opcode);
      end else if (ex_stall_out && !timeout) begin
         state_nxt    = ST_MEM;
         wait_cnt_nxt = wait_cnt + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         ex_opcode <= 7'd0;
         ex_rd     <= 5'd0;
         wait_cnt  <= 8'd0;
         mem_error <= 1'b0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
         if (capture) begin
            ex_opcode <= id_opcode;
            ex_rd     <= id_rd;
         end
         if (timeout)
            mem_error <= 1'b1;
      end
   end

endmodule

`default_nettype wire
